// File: rtl/lbm_cell_gather_if.sv
// rtl/lbm_cell_gather_if.sv - word stream in / 9-word bundle out handshake bundle for lbm_cell_gather
// s_tuser/m_solid exist only when LBM_GATHER_BOUNCEBACK_EN is defined.
interface lbm_cell_gather_if #(
  parameter int DATA_W = 16,
  parameter int NDIR   = 9,
  parameter int IDX_W  = 16
);
  logic [DATA_W-1:0]      s_tdata;
  logic                   s_tvalid;
  logic                   s_tready;
  logic                   s_tlast;
  logic [NDIR*DATA_W-1:0] m_f;
  logic                   m_valid;
  logic                   m_ready;
  logic [IDX_W-1:0]       m_cell_idx;
`ifdef LBM_GATHER_BOUNCEBACK_EN
  logic                   s_tuser;
  logic                   m_solid;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, s_tuser, m_ready,
    output s_tready, m_f, m_valid, m_cell_idx, m_solid
  );
  modport master (
    output s_tdata, s_tvalid, s_tlast, s_tuser, m_ready,
    input  s_tready, m_f, m_valid, m_cell_idx, m_solid
  );
`else
  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_ready,
    output s_tready, m_f, m_valid, m_cell_idx
  );
  modport master (
    output s_tdata, s_tvalid, s_tlast, m_ready,
    input  s_tready, m_f, m_valid, m_cell_idx
  );
`endif
endinterface

// File: rtl/lbm_cell_gather.sv
// rtl/lbm_cell_gather.sv - serial D2Q9 word stream to registered 9-word collider bundle
// Optional half-way bounce-back swap for solid cells under LBM_GATHER_BOUNCEBACK_EN.
module lbm_cell_gather #(
  parameter int DATA_W = 16,
  parameter int NDIR   = 9,
  parameter int IDX_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  lbm_cell_gather_if.slave     bus,
  input  logic                 err_clr,
  output logic                 err_framing,
  output logic                 busy
);

  logic [3:0]             widx;
  logic [DATA_W-1:0]      slot [0:NDIR-2];
  logic [DATA_W-1:0]      w    [0:NDIR-1];
  logic [NDIR*DATA_W-1:0] bundle;
  logic                   rdy_en;
  logic                   at_last;
  logic                   acc;
  logic                   hs;
  logic                   err_set;
`ifdef LBM_GATHER_BOUNCEBACK_EN
  logic                   solid_q;

  // Opposite lattice direction: n<->s, ne<->sw, e<->w, se<->nw, null fixed.
  function automatic int opp(input int k);
    if (k == 0) return 0;
    return ((k + 3) % 8) + 1;
  endfunction
`endif

  assign at_last      = (widx == 4'(NDIR - 1));
  // Only the closing word can stall: it needs the output register free.
  assign bus.s_tready = rdy_en && !(at_last && bus.m_valid && !bus.m_ready);
  assign acc          = bus.s_tvalid && bus.s_tready;
  assign hs           = bus.m_valid && bus.m_ready;
  assign busy         = (widx != 4'd0);
  assign err_set      = acc && (at_last ? !bus.s_tlast : bus.s_tlast);

  always_comb begin
    for (int k = 0; k < NDIR - 1; k++) w[k] = slot[k];
    w[NDIR-1] = bus.s_tdata;
    bundle = '0;
    for (int k = 0; k < NDIR; k++) begin
`ifdef LBM_GATHER_BOUNCEBACK_EN
      bundle[k*DATA_W +: DATA_W] = solid_q ? w[opp(k)] : w[k];
`else
      bundle[k*DATA_W +: DATA_W] = w[k];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      widx           <= '0;
      for (int k = 0; k < NDIR - 1; k++) slot[k] <= '0;
      rdy_en         <= 1'b0;
      bus.m_f        <= '0;
      bus.m_valid    <= 1'b0;
      bus.m_cell_idx <= '0;
      err_framing    <= 1'b0;
`ifdef LBM_GATHER_BOUNCEBACK_EN
      solid_q        <= 1'b0;
      bus.m_solid    <= 1'b0;
`endif
    end else begin
      rdy_en <= 1'b1;
      if (hs) bus.m_cell_idx <= bus.m_cell_idx + 1'b1;

      if (acc && at_last) begin
        bus.m_f     <= bundle;
        bus.m_valid <= 1'b1;
`ifdef LBM_GATHER_BOUNCEBACK_EN
        bus.m_solid <= solid_q;
`endif
      end else if (bus.m_ready) begin
        bus.m_valid <= 1'b0;
      end

      if (acc) begin
        if (at_last || bus.s_tlast) begin
          widx <= '0;
        end else begin
          slot[widx[2:0]] <= bus.s_tdata;
          widx            <= widx + 4'd1;
        end
`ifdef LBM_GATHER_BOUNCEBACK_EN
        if (widx == 4'd0) solid_q <= bus.s_tuser;
`endif
      end

      // A new error outranks a coincident clear.
      err_framing <= err_set | (err_framing & ~err_clr);
    end
  end

endmodule

// File: tb/tb_lbm_cell_gather.sv
// tb/tb_lbm_cell_gather.sv - scoreboard bench for lbm_cell_gather
// Bounce-back scenario compiled only with LBM_GATHER_BOUNCEBACK_EN.
module tb_lbm_cell_gather;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_clr = 1'b0;
  logic err_framing;
  logic busy;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [143:0] f;
    logic [15:0]  idx;
    bit           solid;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_idx = 16'd0;

  lbm_cell_gather_if bus ();

  lbm_cell_gather dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .err_clr     (err_clr),
    .err_framing (err_framing),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1);
  end

  function automatic logic [143:0] model(input logic [15:0] base, input bit solid);
    int          src [9];
    logic [143:0] r;
    src = '{0, 5, 6, 7, 8, 1, 2, 3, 4};
    r = '0;
    for (int k = 0; k < 9; k++)
      r[k*16 +: 16] = base + 16'(solid ? src[k] : k);
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.m_valid && bus.m_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_bundle: got m_f=%h, need no bundle", bus.m_f);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.m_f !== e.f || bus.m_cell_idx !== e.idx) begin
          n_bad++;
          $display("FAIL bundle: got m_f=%h idx=%0d, need m_f=%h idx=%0d",
                   bus.m_f, bus.m_cell_idx, e.f, e.idx);
        end
`ifdef LBM_GATHER_BOUNCEBACK_EN
        n_vec++;
        if (bus.m_solid !== e.solid) begin
          n_bad++;
          $display("FAIL m_solid: got %b, need %b", bus.m_solid, e.solid);
        end
`endif
      end
    end
  end

  // Called between a rising edge and the next falling edge; returns likewise.
  task automatic send_word(input logic [15:0] d, input bit last, input int max_wait, output bit ok);
    bus.s_tdata  = d;
    bus.s_tlast  = last;
    bus.s_tvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk); #1;
      if (bus.s_tready) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      bus.s_tvalid = 1'b0;
      bus.s_tlast  = 1'b0;
    end
  endtask

  task automatic push_exp(input logic [15:0] base, input bit solid);
    exp_t e;
    e.f = model(base, solid);
    e.idx = exp_idx;
    e.solid = solid;
    sb.push_back(e);
    exp_idx = exp_idx + 16'd1;
  endtask

  task automatic send_cell(input logic [15:0] base, input bit last9, input bit solid);
    bit ok;
    for (int k = 0; k < 9; k++) begin
`ifdef LBM_GATHER_BOUNCEBACK_EN
      bus.s_tuser = (k == 0) ? solid : 1'b0;
`endif
      send_word(base + 16'(k), (k == 8) ? last9 : 1'b0, 20, ok);
      n_vec++;
      if (!ok) begin
        n_bad++;
        $display("FAIL accept_timeout: got s_tready=0 at word %0d, need 1", k);
      end else if (k == 8) begin
        push_exp(base, solid);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    n_vec++;
    if (bus.m_valid !== 1'b0 || bus.m_f !== '0 || bus.m_cell_idx !== '0 ||
        err_framing !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values: got v=%b f=%h idx=%0d err=%b busy=%b, need all 0",
               bus.m_valid, bus.m_f, bus.m_cell_idx, err_framing, busy);
    end
    idle(2);
    rst = 1'b0;
    @(posedge clk); #2;
    n_vec++;
    if (bus.s_tready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_reset: got %b, need 1", bus.s_tready);
    end
  endtask

  task automatic test_basic;
    bus.m_ready = 1'b1;
    send_cell(16'h0001, 1'b1, 1'b0);
    #1;
    n_vec++;
    if (bus.m_valid !== 1'b1 || bus.m_f[15:0] !== 16'h0001 ||
        bus.m_f[143:128] !== 16'h0009 || bus.m_cell_idx !== 16'd0) begin
      n_bad++;
      $display("FAIL basic_bundle: got v=%b null=%h nw=%h idx=%0d, need 1 0001 0009 0",
               bus.m_valid, bus.m_f[15:0], bus.m_f[143:128], bus.m_cell_idx);
    end
    idle(3);
  endtask

  task automatic test_back_to_back;
    bit           ok;
    logic [143:0] held;
    bus.m_ready = 1'b0;
    send_cell(16'h0100, 1'b1, 1'b0);
    held = model(16'h0100, 1'b0);
    for (int k = 0; k < 8; k++) begin
      send_word(16'h0200 + 16'(k), 1'b0, 2, ok);
      n_vec++;
      if (!ok) begin
        n_bad++;
        $display("FAIL b2b_word_accept: got stall at word %0d, need accept", k);
      end
    end
    send_word(16'h0208, 1'b1, 3, ok);
    n_vec++;
    if (ok) begin
      n_bad++;
      $display("FAIL b2b_stall: got word 8 accepted, need stall");
    end
    n_vec++;
    if (bus.s_tready !== 1'b0 || bus.m_valid !== 1'b1 || bus.m_f !== held ||
        bus.m_cell_idx !== exp_idx - 16'd1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_hold: got rdy=%b v=%b f=%h idx=%0d, need 0 1 %h %0d",
               bus.s_tready, bus.m_valid, bus.m_f, bus.m_cell_idx, held, exp_idx - 16'd1);
    end
    bus.m_ready = 1'b1;
    send_word(16'h0208, 1'b1, 5, ok);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL b2b_release: got word 8 still stalled, need accept");
    end else begin
      push_exp(16'h0200, 1'b0);
    end
    #1;
    n_vec++;
    if (bus.m_valid !== 1'b1 || bus.m_f !== model(16'h0200, 1'b0)) begin
      n_bad++;
      $display("FAIL b2b_second: got v=%b f=%h, need 1 %h",
               bus.m_valid, bus.m_f, model(16'h0200, 1'b0));
    end
    idle(3);
  endtask

  task automatic test_framing_early;
    bit ok;
    bus.m_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send_word(16'h0300 + 16'(k), (k == 4), 2, ok);
    end
    #1;
    n_vec++;
    if (err_framing !== 1'b1 || bus.m_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL early_tlast: got err=%b v=%b busy=%b, need 1 0 0",
               err_framing, bus.m_valid, busy);
    end
    send_cell(16'h0310, 1'b1, 1'b0);
    idle(2);
    n_vec++;
    if (err_framing !== 1'b1) begin
      n_bad++;
      $display("FAIL err_sticky: got %b, need 1", err_framing);
    end
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    #1;
    n_vec++;
    if (err_framing !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clr: got %b, need 0", err_framing);
    end
  endtask

  task automatic test_framing_missing_last;
    bit ok;
    bus.m_ready = 1'b1;
    send_cell(16'h0400, 1'b0, 1'b0);
    #1;
    n_vec++;
    if (err_framing !== 1'b1 || bus.m_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL missing_tlast: got err=%b v=%b, need 1 1", err_framing, bus.m_valid);
    end
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    for (int k = 0; k < 8; k++) send_word(16'h0410 + 16'(k), 1'b0, 2, ok);
    err_clr = 1'b1;
    send_word(16'h0418, 1'b0, 2, ok);
    err_clr = 1'b0;
    if (ok) push_exp(16'h0410, 1'b0);
    #1;
    n_vec++;
    if (err_framing !== 1'b1) begin
      n_bad++;
      $display("FAIL err_vs_clr: got %b, need 1", err_framing);
    end
    idle(3);
  endtask

  task automatic test_async_reset;
    bit ok;
    bus.m_ready = 1'b0;
    send_cell(16'h0500, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) send_word(16'h0510 + 16'(k), 1'b0, 2, ok);
    #3;
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.m_valid !== 1'b0 || bus.m_f !== '0 || bus.m_cell_idx !== '0 ||
        err_framing !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got v=%b f=%h idx=%0d err=%b busy=%b, need all 0",
               bus.m_valid, bus.m_f, bus.m_cell_idx, err_framing, busy);
    end
    sb.delete();
    exp_idx = 16'd0;
    idle(2);
    rst = 1'b0;
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    send_cell(16'h0600, 1'b1, 1'b0);
    idle(3);
  endtask

`ifdef LBM_GATHER_BOUNCEBACK_EN
  task automatic test_bounceback;
    bus.m_ready = 1'b1;
    send_cell(16'h0001, 1'b1, 1'b1);
    #1;
    n_vec++;
    if (bus.m_solid !== 1'b1 || bus.m_f[31:16] !== 16'h0006 || bus.m_f[95:80] !== 16'h0002) begin
      n_bad++;
      $display("FAIL bounceback: got solid=%b n=%h s=%h, need 1 0006 0002",
               bus.m_solid, bus.m_f[31:16], bus.m_f[95:80]);
    end
    send_cell(16'h0700, 1'b1, 1'b0);
    idle(3);
  endtask
`endif

  initial begin
    bus.s_tdata  = '0;
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    bus.m_ready  = 1'b0;
`ifdef LBM_GATHER_BOUNCEBACK_EN
    bus.s_tuser  = 1'b0;
`endif
    test_reset();
    test_basic();
    test_back_to_back();
    test_framing_early();
    test_framing_missing_last();
    test_async_reset();
`ifdef LBM_GATHER_BOUNCEBACK_EN
    test_bounceback();
`endif
    idle(5);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d bundles outstanding, need 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
